// File: rtl/i2c_target_regs_pkg.sv
// I2C target register bridge: shared types and constants.
// State encoding, R/W bit position and default device address.
package i2c_target_regs_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        REGA,
        REGA_ACK,
        WDAT,
        WDAT_ACK,
        RDAT,
        RACK,
        WAIT
    } state_e;

    localparam int         RW_BIT        = 0;
    localparam logic [6:0] DEF_DEV_ADDR  = 7'h50;
    localparam logic [3:0] BITS_PER_BYTE = 4'd8;

endpackage

// File: rtl/i2c_line_sync.sv
// I2C target: SCL/SDA synchronizers and bus-event detection.
// Produces synchronized SDA level, SCL edges and START/STOP strobes.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_dly_q;
    logic                   sda_dly_q;
    logic                   scl_s;

    // Synchronizer chains plus one delayed copy; idle bus reads high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_dly_q  <= 1'b1;
            sda_dly_q  <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
            scl_dly_q  <= scl_sync_q[SYNC_STAGES-1];
            sda_dly_q  <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_dly_q;
    assign scl_fall  = ~scl_s & scl_dly_q;
    assign start_det = scl_s & scl_dly_q & sda_dly_q & ~sda_s;
    assign stop_det  = scl_s & scl_dly_q & ~sda_dly_q & sda_s;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with single-cycle register-access port.
// Byte FSM, shift register and register port; line sync in submodule.
module i2c_target_regs
    import i2c_target_regs_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = DEF_DEV_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    state_e     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [3:0] cnt_q, cnt_d;
    logic       rw_q, rw_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] reg_addr_q, reg_addr_d;
    logic [7:0] reg_wdata_q, reg_wdata_d;
    logic       reg_we_q, reg_we_d;
    logic       reg_re_q, reg_re_d;
    logic       busy_q, busy_d;
    logic       rd_pend_q;

    i2c_line_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rstn      (rstn),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    // State and output registers; reset releases SDA at once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            rw_q        <= 1'b0;
            sda_oe_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            busy_q      <= 1'b0;
            rd_pend_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            rw_q        <= rw_d;
            sda_oe_q    <= sda_oe_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            reg_re_q    <= reg_re_d;
            busy_q      <= busy_d;
            rd_pend_q   <= reg_re_q;
        end
    end

    // Byte FSM: bits sampled on SCL rise, SDA drive moves on SCL fall.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        rw_d        = rw_q;
        sda_oe_d    = sda_oe_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = 1'b0;
        reg_re_d    = 1'b0;
        busy_d      = busy_q;
        if (rd_pend_q) begin
            shift_d = reg_rdata;
        end
        if (start_det) begin
            state_d  = ADDR;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (stop_det) begin
            state_d  = IDLE;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: ;
                ADDR: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_s};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == BITS_PER_BYTE) begin
                        cnt_d = '0;
                        if (shift_q[7:1] == DEV_ADDR) begin
                            state_d  = ADDR_ACK;
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                            rw_d     = shift_q[RW_BIT];
                        end else begin
                            state_d = WAIT;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_rise && rw_q) begin
                        reg_re_d = 1'b1;
                    end else if (scl_fall) begin
                        if (rw_q) begin
                            state_d  = RDAT;
                            sda_oe_d = ~shift_q[7];
                        end else begin
                            state_d  = REGA;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                REGA: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_s};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == BITS_PER_BYTE) begin
                        state_d  = REGA_ACK;
                        sda_oe_d = 1'b1;
                        cnt_d    = '0;
                    end
                end
                REGA_ACK: begin
                    if (scl_fall) begin
                        reg_addr_d = shift_q;
                        sda_oe_d   = 1'b0;
                        state_d    = WDAT;
                    end
                end
                WDAT: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_s};
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == BITS_PER_BYTE - 4'd1) begin
                            reg_wdata_d = {shift_q[6:0], sda_s};
                            reg_we_d    = 1'b1;
                        end
                    end else if (scl_fall && cnt_q == BITS_PER_BYTE) begin
                        state_d  = WDAT_ACK;
                        sda_oe_d = 1'b1;
                        cnt_d    = '0;
                    end
                end
                WDAT_ACK: begin
                    if (scl_fall) begin
                        reg_addr_d = reg_addr_q + 8'd1;
                        sda_oe_d   = 1'b0;
                        state_d    = WDAT;
                    end
                end
                RDAT: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == BITS_PER_BYTE) begin
                            state_d  = RACK;
                            sda_oe_d = 1'b0;
                            cnt_d    = '0;
                        end else begin
                            sda_oe_d = ~shift_q[~cnt_q[2:0]];
                        end
                    end
                end
                RACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            reg_addr_d = reg_addr_q + 8'd1;
                            reg_re_d   = 1'b1;
                            cnt_d      = 4'd1;
                        end else begin
                            state_d = WAIT;
                            busy_d  = 1'b0;
                        end
                    end else if (scl_fall && cnt_q == 4'd1) begin
                        state_d  = RDAT;
                        sda_oe_d = ~shift_q[7];
                        cnt_d    = '0;
                    end
                end
                WAIT: ;
                default: state_d = IDLE;
            endcase
        end
    end

    assign sda_oe    = sda_oe_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_we    = reg_we_q;
    assign reg_re    = reg_re_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-level initiator, register bank
// model and transaction-level pointer model with random traffic.
module tb_i2c_target_regs;

    localparam int         SYNC = 2;
    localparam int         Q    = 5;
    localparam logic [6:0] DEV  = 7'h50;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       scl_in, sda_in;
    logic       sda_oe;
    logic [7:0] reg_addr, reg_wdata;
    logic       reg_we, reg_re, busy;
    logic [7:0] reg_rdata = 8'h00;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] we_q[$];
    logic [7:0]  re_q[$];
    logic [7:0]  wlist[$];
    bit          busy_seen, oe_seen;
    logic [7:0]  m_ptr = 8'h00;

    assign scl_in = scl_m;
    assign sda_in = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target_regs #(
        .DEV_ADDR    (DEV),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda_oe    (sda_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    // Register bank: registered read returning addr ^ 0xFF.
    always @(posedge clk) begin
        if (reg_re) reg_rdata <= reg_addr ^ 8'hFF;
    end

    // Log register-port activity and transfer flags.
    always @(negedge clk) begin
        if (rstn) begin
            if (reg_we) we_q.push_back({reg_addr, reg_wdata});
            if (reg_re) re_q.push_back(reg_addr);
            if (busy) busy_seen = 1'b1;
            if (sda_oe) oe_seen = 1'b1;
        end
    end

    int   hi_cnt = 0;
    logic prev_oe = 1'b0;
    logic prev_rstn = 1'b0;

    // SDA drive must hold steady while synchronized SCL is high.
    always @(negedge clk) begin
        if (rstn && prev_rstn && hi_cnt >= SYNC + 2) begin
            n_assert++;
            assert (sda_oe === prev_oe) else begin
                n_fail++;
                $error("FAIL oe_scl_high observed=%0b expected=%0b",
                       sda_oe, prev_oe);
            end
        end
        hi_cnt    = scl_in ? hi_cnt + 1 : 0;
        prev_oe   = sda_oe;
        prev_rstn = rstn;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic bit_x(input logic b, output logic r);
        sda_m = b;
        tick(Q);
        scl_m = 1'b1;
        tick(Q);
        r = sda_in;
        tick(Q);
        scl_m = 1'b0;
        tick(Q);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        tick(Q);
        scl_m = 1'b1;
        tick(Q);
        sda_m = 1'b0;
        tick(Q);
        scl_m = 1'b0;
        tick(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        tick(Q);
        scl_m = 1'b1;
        tick(Q);
        sda_m = 1'b1;
        tick(2 * Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_x(d[i], r);
        bit_x(1'b1, r);
        ack = ~r;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_x(1'b1, r);
            d[i] = r;
        end
        bit_x(nack, r);
    endtask

    task automatic clear_logs();
        we_q.delete();
        re_q.delete();
        busy_seen = 1'b0;
        oe_seen   = 1'b0;
    endtask

    // Write: address a, pointer p, then every byte in wlist.
    task automatic xfer_write(input string tag, input logic [6:0] a,
                              input logic [7:0] p);
        logic        ack, match;
        logic [15:0] exp_we[$];
        match = (a == DEV);
        clear_logs();
        i2c_start();
        write_byte({a, 1'b0}, ack);
        chk({tag, " addr_ack"}, ack, match);
        write_byte(p, ack);
        chk({tag, " ptr_ack"}, ack, match);
        if (match) m_ptr = p;
        foreach (wlist[k]) begin
            write_byte(wlist[k], ack);
            chk({tag, " data_ack"}, ack, match);
            if (match) begin
                exp_we.push_back({m_ptr, wlist[k]});
                m_ptr = m_ptr + 8'd1;
            end
        end
        i2c_stop();
        chk({tag, " busy_after_stop"}, busy, 0);
        chk({tag, " busy_seen"}, busy_seen, match);
        chk({tag, " oe_seen"}, oe_seen, match);
        chk({tag, " re_count"}, re_q.size(), 0);
        chk({tag, " we_count"}, we_q.size(), exp_we.size());
        for (int i = 0; i < exp_we.size(); i++) begin
            if (i < we_q.size()) chk({tag, " we_addr_data"}, we_q[i], exp_we[i]);
        end
    endtask

    // Read n bytes, optionally setting the pointer first via restart.
    task automatic xfer_read(input string tag, input bit set_ptr,
                             input logic [7:0] p, input int n);
        logic       ack;
        logic [7:0] d, ea;
        clear_logs();
        i2c_start();
        if (set_ptr) begin
            write_byte({DEV, 1'b0}, ack);
            chk({tag, " waddr_ack"}, ack, 1);
            write_byte(p, ack);
            chk({tag, " ptr_ack"}, ack, 1);
            m_ptr = p;
            i2c_start();
        end
        write_byte({DEV, 1'b1}, ack);
        chk({tag, " raddr_ack"}, ack, 1);
        for (int i = 0; i < n; i++) begin
            ea = m_ptr + 8'(i);
            read_byte(i == n - 1, d);
            chk({tag, " rdata"}, d, ea ^ 8'hFF);
        end
        chk({tag, " sda_released"}, sda_oe, 0);
        chk({tag, " busy_after_nack"}, busy, 0);
        i2c_stop();
        chk({tag, " we_count"}, we_q.size(), 0);
        chk({tag, " re_count"}, re_q.size(), n);
        for (int i = 0; i < n; i++) begin
            ea = m_ptr + 8'(i);
            if (i < re_q.size()) chk({tag, " re_addr"}, re_q[i], ea);
        end
        m_ptr = m_ptr + 8'(n - 1);
    endtask

    initial begin
        logic       ack, r;
        logic [6:0] a;
        int         op, n;

        tick(3);
        chk("rst sda_oe", sda_oe, 0);
        chk("rst reg_addr", reg_addr, 0);
        chk("rst reg_wdata", reg_wdata, 0);
        chk("rst reg_we", reg_we, 0);
        chk("rst reg_re", reg_re, 0);
        chk("rst busy", busy, 0);
        rstn = 1'b1;
        tick(10);

        wlist = '{8'hA5, 8'h3C};
        xfer_write("wr2", DEV, 8'h10);

        xfer_read("rd_restart", 1'b1, 8'h20, 2);

        wlist = '{8'h77};
        xfer_write("bad_addr", 7'h51, 8'h33);

        wlist = '{8'h11, 8'h22};
        xfer_write("wrap", DEV, 8'hFF);

        // Reset asserted during bit 4 of a data byte.
        i2c_start();
        write_byte({DEV, 1'b0}, ack);
        write_byte(8'h40, ack);
        for (int i = 7; i >= 4; i--) bit_x(1'b0, r);
        chk("midrst busy_before", busy, 1);
        rstn = 1'b0;
        #1;
        chk("midrst sda_oe", sda_oe, 0);
        chk("midrst busy", busy, 0);
        chk("midrst reg_addr", reg_addr, 0);
        tick(3);
        rstn = 1'b1;
        m_ptr = 8'h00;
        sda_m = 1'b1;
        tick(Q);
        scl_m = 1'b1;
        tick(4 * Q);
        xfer_read("rd_after_rst", 1'b0, 8'h00, 1);
        wlist = '{8'h5A};
        xfer_write("wr_after_rst", DEV, 8'h08);

        // STOP three bits into a data byte.
        clear_logs();
        i2c_start();
        write_byte({DEV, 1'b0}, ack);
        write_byte(8'h40, ack);
        m_ptr = 8'h40;
        for (int i = 0; i < 3; i++) bit_x(1'b1, r);
        i2c_stop();
        chk("stop_mid we_count", we_q.size(), 0);
        chk("stop_mid busy", busy, 0);
        xfer_read("rd_after_stop", 1'b0, 8'h00, 2);

        for (int t = 0; t < 8; t++) begin
            op = $urandom_range(0, 2);
            n  = $urandom_range(1, 3);
            if (op == 0) begin
                a = DEV;
                if ($urandom_range(0, 3) == 0) begin
                    a = 7'($urandom_range(0, 127));
                    if (a == DEV) a = DEV + 7'd1;
                end
                wlist.delete();
                for (int k = 0; k < n - 1; k++) wlist.push_back(8'($urandom));
                xfer_write("rnd_wr", a, 8'($urandom));
            end else begin
                xfer_read("rnd_rd", op == 2, 8'($urandom), n);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
